md_scheduler: RTL and testbench

//  Sequences the multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.

---
 rtl/md_scheduler_if.sv | 23 ++
 rtl/md_scheduler.sv | 136 +++++++++++++
 tb/tb_md_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/md_scheduler_if.sv
// Issue/result bundle between the E-stage decode and the multiply/divide scheduler.
interface md_scheduler_if;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_d;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  start, mdop, rs_val, rt_val, md_use_d,
        output busy, done, stall, hi, lo
    );

    modport master (
        output start, mdop, rs_val, rt_val, md_use_d,
        input  busy, done, stall, hi, lo
    );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle mult/div sequencer with HI/LO commit and D-stage stall.
// Optional MD_CANCEL_EN adds cancel_i to abort an in-flight op without committing.
module md_scheduler #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    md_scheduler_if.slave        md
`ifdef MD_CANCEL_EN
    ,
    input  logic                 cancel_i
`endif
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, lo_q;
    logic [63:0]       sh_q, sh_d;
    logic              commit, busy, done, cancel_w, issue_ok;
    logic              op_mult, op_div, op_mthi, op_mtlo;

`ifdef MD_CANCEL_EN
    assign cancel_w = cancel_i;
`else
    assign cancel_w = 1'b0;
`endif

    assign op_mult  = (md.mdop[2:1] == 2'b00);
    assign op_div   = (md.mdop[2:1] == 2'b01);
    assign op_mthi  = (md.mdop == 3'b100);
    assign op_mtlo  = (md.mdop == 3'b101);
    assign issue_ok = md.start & ~cancel_w & (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_ok && op_mult) begin
                    state_d = RUN;
                    cnt_d   = MULT_CNT;
                end else if (issue_ok && op_div) begin
                    state_d = RUN;
                    cnt_d   = DIV_CNT;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cancel_w) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    done    = 1'b1;
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Division works on magnitudes so signed overflow (MIN / -1) needs no special case.
    logic        rs_neg, rt_neg, rt_zero;
    logic [31:0] abs_rs, abs_rt, divisor, q_mag, r_mag, quo, rem;
    logic [63:0] ma, mb;

    always_comb begin
        rs_neg  = md.rs_val[31] & ~md.mdop[0];
        rt_neg  = md.rt_val[31] & ~md.mdop[0];
        rt_zero = (md.rt_val == 32'd0);
        abs_rs  = rs_neg ? (32'd0 - md.rs_val) : md.rs_val;
        abs_rt  = rt_neg ? (32'd0 - md.rt_val) : md.rt_val;
        divisor = rt_zero ? 32'd1 : abs_rt;
        q_mag   = abs_rs / divisor;
        r_mag   = abs_rs % divisor;
        quo     = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = rs_neg ? (32'd0 - r_mag) : r_mag;
        if (rt_zero) begin
            quo = 32'hFFFF_FFFF;
            rem = md.rs_val;
        end
        ma   = md.mdop[0] ? {32'd0, md.rs_val} : {{32{md.rs_val[31]}}, md.rs_val};
        mb   = md.mdop[0] ? {32'd0, md.rt_val} : {{32{md.rt_val[31]}}, md.rt_val};
        sh_d = op_div ? {rem, quo} : (ma * mb);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sh_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (issue_ok && (op_mult || op_div))
                sh_q <= sh_d;
            if (commit) begin
                hi_q <= sh_q[63:32];
                lo_q <= sh_q[31:0];
            end else if (issue_ok && op_mthi) begin
                hi_q <= md.rs_val;
            end else if (issue_ok && op_mtlo) begin
                lo_q <= md.rs_val;
            end
        end
    end

    assign md.busy  = busy;
    assign md.done  = done;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
    assign md.stall = md.md_use_d & (busy | (md.start & ~md.mdop[2]));

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed cases plus random mult/div against a 64-bit arithmetic model.
module tb_md_scheduler;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    md_scheduler_if mdi();

`ifdef MD_CANCEL_EN
    logic cancel = 1'b0;
    md_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .md(mdi.slave), .cancel_i(cancel));
`else
    md_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .md(mdi.slave));
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference result {hi,lo} straight from the arithmetic definitions.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint a, b, q, r;
        logic [63:0] ua, ub;
        case (op)
            3'd0: begin a = longint'($signed(rs)); b = longint'($signed(rt)); q = a * b; return q; end
            3'd1: begin ua = {32'd0, rs}; ub = {32'd0, rt}; return ua * ub; end
            3'd2: begin
                if (rt == 0) return {rs, 32'hFFFF_FFFF};
                a = longint'($signed(rs)); b = longint'($signed(rt));
                q = a / b; r = a % b;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (rt == 0) return {rs, 32'hFFFF_FFFF};
                return {rs % rt, rs / rt};
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit use_d, input bit collide);
        int lat;
        logic [63:0] r;
        lat = op[1] ? DIV_LAT : MULT_LAT;
        r = ref_md(op, rs, rt);
        @(negedge clk);
        mdi.start = 1'b1; mdi.mdop = op; mdi.rs_val = rs; mdi.rt_val = rt; mdi.md_use_d = use_d;
        #1 check("stall_issue", 64'(mdi.stall), 64'(use_d));
        check("busy_issue", 64'(mdi.busy), 64'd0);
        @(posedge clk);
        #1 mdi.start = 1'b0; mdi.rs_val = $urandom; mdi.rt_val = $urandom;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check("busy_run", 64'(mdi.busy), 64'd1);
            check("done_run", 64'(mdi.done), 64'(c == lat));
            check("stall_run", 64'(mdi.stall), 64'(use_d));
            if (c == lat) check("hilo_hold", {mdi.hi, mdi.lo}, {exp_hi, exp_lo});
            mdi.start = collide && (c == 2);
            if (collide && c == 2) mdi.mdop = 3'($urandom_range(0, 5));
        end
        @(negedge clk);
        check("busy_end", 64'(mdi.busy), 64'd0);
        check("done_end", 64'(mdi.done), 64'd0);
        check("stall_end", 64'(mdi.stall), 64'd0);
        check("hilo_commit", {mdi.hi, mdi.lo}, r);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        mdi.md_use_d = 1'b0;
    endtask

    task automatic wr_op(input logic [2:0] op, input logic [31:0] rs);
        @(negedge clk);
        mdi.start = 1'b1; mdi.mdop = op; mdi.rs_val = rs; mdi.md_use_d = 1'b1;
        #1 check("stall_mtx", 64'(mdi.stall), 64'd0);
        @(posedge clk);
        #1 mdi.start = 1'b0; mdi.md_use_d = 1'b0;
        if (op == 3'd4) exp_hi = rs;
        if (op == 3'd5) exp_lo = rs;
        @(negedge clk);
        check("busy_mtx", 64'(mdi.busy), 64'd0);
        check("hilo_mtx", {mdi.hi, mdi.lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] rs, rt;
        mdi.start = 1'b0; mdi.mdop = 3'd0; mdi.rs_val = 32'd0; mdi.rt_val = 32'd0; mdi.md_use_d = 1'b0;
        #1;
        check("rst_hilo", {mdi.hi, mdi.lo}, 64'd0);
        check("rst_busy", 64'(mdi.busy), 64'd0);
        check("rst_done", 64'(mdi.done), 64'd0);
        @(negedge clk); reset_n = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
        check("mult_m3x7", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        check("divu_100_7", {mdi.hi, mdi.lo}, {32'd2, 32'd14});
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_m7_2", {mdi.hi, mdi.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(3'd2, 32'd5, 32'd0, 1'b1, 1'b0);
        check("div_by_0", {mdi.hi, mdi.lo}, {32'd5, 32'hFFFF_FFFF});
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf", {mdi.hi, mdi.lo}, {32'd0, 32'h8000_0000});
        run_op(3'd0, 32'd4, 32'd6, 1'b0, 1'b0);

        wr_op(3'd4, 32'h0000_1234);
        check("mthi_val", 64'(mdi.hi), 64'h1234);
        wr_op(3'd5, 32'hCAFE_F00D);
        wr_op(3'd6, 32'hDEAD_BEEF);
        wr_op(3'd7, 32'h0BAD_0BAD);

        for (int k = 0; k < 12; k++) begin
            op = 3'($urandom_range(0, 3));
            rs = $urandom;
            rt = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (k % 4 == 1) rt = 32'($urandom_range(1, 9));
            run_op(op, rs, rt, 1'($urandom_range(0, 1)), (k % 3) == 0);
        end

`ifdef MD_CANCEL_EN
        @(negedge clk);
        mdi.start = 1'b1; mdi.mdop = 3'd2; mdi.rs_val = 32'd1000; mdi.rt_val = 32'd3;
        @(posedge clk);
        #1 mdi.start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("cxl_busy", 64'(mdi.busy), 64'd1);
            check("cxl_done", 64'(mdi.done), 64'd0);
        end
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("cxl_idle", 64'(mdi.busy), 64'd0);
            check("cxl_nodone", 64'(mdi.done), 64'd0);
        end
        check("cxl_hilo", {mdi.hi, mdi.lo}, {exp_hi, exp_lo});
        @(negedge clk);
        mdi.start = 1'b1; mdi.mdop = 3'd4; mdi.rs_val = 32'h5555_AAAA; cancel = 1'b1;
        @(posedge clk);
        #1 mdi.start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        check("cxl_start_ign", {mdi.hi, mdi.lo}, {exp_hi, exp_lo});
        check("cxl_start_busy", 64'(mdi.busy), 64'd0);
`else
        run_op(3'd2, 32'd1000, 32'd3, 1'b0, 1'b0);
        check("nocxl_commit", {mdi.hi, mdi.lo}, {32'd1, 32'd333});
`endif

        // Asynchronous reset in the middle of a divide, away from any clock edge.
        @(negedge clk);
        mdi.start = 1'b1; mdi.mdop = 3'd3; mdi.rs_val = 32'd77; mdi.rt_val = 32'd5;
        @(posedge clk);
        #1 mdi.start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst_hilo", {mdi.hi, mdi.lo}, 64'd0);
        check("arst_busy", 64'(mdi.busy), 64'd0);
        check("arst_done", 64'(mdi.done), 64'd0);
        exp_hi = 32'd0; exp_lo = 32'd0;
        @(negedge clk); reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("arst_nocommit", {mdi.hi, mdi.lo, 31'd0, mdi.busy}, 128'd0);
        end
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
